// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions used by ahb_master and the SRAM slave.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] BYTE = 3'b000;
    localparam logic [2:0] HALF = 3'b001;
    localparam logic [2:0] WORD = 3'b010;

    typedef enum logic [2:0] {
        SINGLE = 3'b000,
        INCR   = 3'b001,
        WRAP4  = 3'b010,
        INCR4  = 3'b011,
        WRAP8  = 3'b100,
        INCR8  = 3'b101,
        WRAP16 = 3'b110,
        INCR16 = 3'b111
    } hburst_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        SLV_IDLE = 2'b00,
        SLV_WAIT = 2'b01,
        SLV_ERR1 = 2'b10,
        SLV_ERR2 = 2'b11
    } slv_state_t;

    // Byte-lane enables for a transfer; all-zero flags an illegal size or misalignment.
    function automatic logic [3:0] lane_mask(input logic [1:0] addr_lo, input logic [2:0] size);
        logic [3:0] mask;
        case (size)
            BYTE:    mask = 4'b0001 << addr_lo;
            HALF:    mask = addr_lo[0] ? 4'b0000 : (addr_lo[1] ? 4'b1100 : 4'b0011);
            WORD:    mask = (addr_lo == 2'b00) ? 4'b1111 : 4'b0000;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ahb_sram_core.sv
// Byte-enabled word memory: synchronous write, combinational read.
module ahb_sram_core #(
    parameter int DEPTH = 256,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] widx,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] ridx,
    output logic [31:0]      rdata
);

    logic [31:0] mem_r [DEPTH];

    // Lane-wise write of the enabled bytes.
    always_ff @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (we && be[l]) begin
                mem_r[widx][8*l +: 8] <= wdata[8*l +: 8];
            end
        end
    end

    assign rdata = mem_r[ridx];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite slave backed by a byte-enabled SRAM, with optional wait states
// and a two-cycle ERROR response for illegal transfers.
module ahb_lite_sram_slave
    import ahb_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          DATA_WIDTH  = 32,
    parameter logic [31:0] BASE_ADDR   = 32'hC000_0000,
    parameter int          MEM_DEPTH   = 256,
    parameter int          WAIT_STATES = 0
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_hsel,
    input  logic [ADDR_WIDTH-1:0] i_haddr,
    input  logic [1:0]            i_htrans,
    input  logic                  i_hwrite,
    input  logic [2:0]            i_hsize,
    input  logic [2:0]            i_hburst,
    input  logic [3:0]            i_hprot,
    input  logic [DATA_WIDTH-1:0] i_hwdata,
    input  logic                  i_hready,
    output logic [DATA_WIDTH-1:0] o_hrdata,
    output logic                  o_hreadyout,
    output logic                  o_hresp
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] BASE_A    = BASE_ADDR[ADDR_WIDTH-1:0];
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(4 * MEM_DEPTH);
    localparam logic [2:0] WS3 = 3'(WAIT_STATES);

    localparam logic [1:0] ST_IDLE = SLV_IDLE;
    localparam logic [1:0] ST_WAIT = SLV_WAIT;
    localparam logic [1:0] ST_ERR1 = SLV_ERR1;
    localparam logic [1:0] ST_ERR2 = SLV_ERR2;

    logic [1:0]            state_r, state_nx_s;
    logic [2:0]            wait_cnt_r, cnt_nx_s;
    logic                  hreadyout_r, hresp_r;
    logic [31:0]           hrdata_r;
    logic                  dp_valid_r, dp_write_r;
    logic [3:0]            dp_be_r;
    logic [IDX_W-1:0]      dp_idx_r;
    logic [ADDR_WIDTH-1:0] off_s;
    logic                  in_range_s, legal_s, accept_s, we_s, rd_cap_s, dp_end_s;
    logic [3:0]            lanes_s;
    logic [IDX_W-1:0]      idx_s, ridx_s;
    logic [31:0]           mem_rdata_s, rdata_fwd_s;
    logic                  unused_s;

    assign unused_s   = ^{i_hburst, i_hprot};
    assign off_s      = i_haddr - BASE_A;
    assign in_range_s = (i_haddr >= BASE_A) && (off_s < MEM_BYTES);
    assign lanes_s    = lane_mask(i_haddr[1:0], i_hsize);
    assign legal_s    = in_range_s && (lanes_s != 4'b0000);
    assign idx_s      = off_s[IDX_W+1:2];
    assign accept_s   = i_hsel && i_hready && i_htrans[1] && hreadyout_r;
    assign dp_end_s   = dp_valid_r && hreadyout_r;
    assign we_s       = dp_end_s && dp_write_r;

    // Read data is fetched on the edge that opens the ready data-phase cycle.
    assign rd_cap_s = (accept_s && legal_s && !i_hwrite && (WAIT_STATES == 0)) ||
                      ((state_r == ST_WAIT) && (wait_cnt_r == 3'd1) && dp_valid_r && !dp_write_r);
    assign ridx_s   = (state_r == ST_WAIT) ? dp_idx_r : idx_s;

    ahb_sram_core #(.DEPTH(MEM_DEPTH), .IDX_W(IDX_W)) u_core (
        .clk   (i_clk),
        .we    (we_s),
        .be    (dp_be_r),
        .widx  (dp_idx_r),
        .wdata (i_hwdata),
        .ridx  (ridx_s),
        .rdata (mem_rdata_s)
    );

    // A write committing on the same edge as a read fetch of that word supplies the new bytes.
    always_comb begin
        rdata_fwd_s = mem_rdata_s;
        for (int l = 0; l < 4; l++) begin
            if (we_s && dp_be_r[l] && (dp_idx_r == ridx_s)) begin
                rdata_fwd_s[8*l +: 8] = i_hwdata[8*l +: 8];
            end else begin
                rdata_fwd_s[8*l +: 8] = mem_rdata_s[8*l +: 8];
            end
        end
    end

    // Slave FSM next-state and wait counter.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = wait_cnt_r;
        case (state_r)
            ST_IDLE, ST_ERR2: begin
                if (accept_s && !legal_s) begin
                    state_nx_s = ST_ERR1;
                end else if (accept_s && (WAIT_STATES != 0)) begin
                    state_nx_s = ST_WAIT;
                    cnt_nx_s   = WS3;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == 3'd1) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    cnt_nx_s = wait_cnt_r - 3'd1;
                end
            end
            ST_ERR1: state_nx_s = ST_ERR2;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State, response outputs and read data register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r     <= ST_IDLE;
            wait_cnt_r  <= 3'd0;
            hreadyout_r <= 1'b1;
            hresp_r     <= HRESP_OKAY;
            hrdata_r    <= 32'h0000_0000;
        end else begin
            state_r     <= state_nx_s;
            wait_cnt_r  <= cnt_nx_s;
            hreadyout_r <= (state_nx_s == ST_IDLE) || (state_nx_s == ST_ERR2);
            hresp_r     <= ((state_nx_s == ST_ERR1) || (state_nx_s == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
            hrdata_r    <= rd_cap_s ? rdata_fwd_s : hrdata_r;
        end
    end

    // Latched address-phase information for the pending data phase.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            dp_valid_r <= 1'b0;
            dp_write_r <= 1'b0;
            dp_be_r    <= 4'b0000;
            dp_idx_r   <= '0;
        end else if (accept_s) begin
            dp_valid_r <= legal_s;
            dp_write_r <= i_hwrite;
            dp_be_r    <= lanes_s;
            dp_idx_r   <= idx_s;
        end else if (dp_end_s) begin
            dp_valid_r <= 1'b0;
        end else begin
            dp_valid_r <= dp_valid_r;
        end
    end

    assign o_hrdata    = hrdata_r;
    assign o_hreadyout = hreadyout_r;
    assign o_hresp     = hresp_r;

endmodule
